clk_div_ctrl: RTL and testbench

Reconfiguration sequencer that sits directly upstream of the integer clock divider and drives its enable and ratio inputs. Accepts new divide ratios over a valid/ready handshake. Applies each new ratio glitch-safely: gates the divider off, drains, loads the ratio, lets it settle, then re-enables. The divider's ratio input therefore never changes while the divider is enabled.

---
 rtl/clk_div_ctrl.sv | 152 +++++++++++++++
 tb/tb_clk_div_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// Glitch-safe reconfiguration sequencer driving the enable and ratio inputs of an integer clock divider.
// Optional macro CLK_DIV_CTRL_RANGE_CHECK_EN: rejects ratios below 2 and reports them on err_o.
module clk_div_ctrl #(
  parameter int DIV_WIDTH     = 8,
  parameter int RESET_RATIO   = 4,
  parameter int DRAIN_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 testmode_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [DIV_WIDTH-1:0] cfg_ratio_i,
  input  logic                 cfg_en_i,
  output logic                 div_en_o,
  output logic [DIV_WIDTH-1:0] div_ratio_o,
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
  output logic                 err_o,
`endif
  output logic                 busy_o
);

  localparam int MAX_CYC = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [DIV_WIDTH-1:0] r_pend_ratio;
  logic [DIV_WIDTH-1:0] w_pend_ratio_nxt;
  logic                 r_pend_en;
  logic                 w_pend_en_nxt;
  logic                 r_div_en;
  logic                 w_div_en_nxt;
  logic [DIV_WIDTH-1:0] r_div_ratio;
  logic [DIV_WIDTH-1:0] w_div_ratio_nxt;
  logic                 w_xfer;
  logic                 w_reject;
  logic [DIV_WIDTH-1:0] w_ratio_san;

  assign cfg_ready_o = (r_state == ST_STABLE) && !testmode_i;
  assign busy_o      = (r_state != ST_STABLE);
  assign div_en_o    = r_div_en;
  assign div_ratio_o = r_div_ratio;
  assign w_xfer      = cfg_valid_i && cfg_ready_o;

`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
  logic r_err;
  logic w_err_nxt;

  assign w_ratio_san = cfg_ratio_i;
  assign w_reject    = (cfg_ratio_i < DIV_WIDTH'(2));
  assign w_err_nxt   = w_xfer && w_reject;
  assign err_o       = r_err;

  // One-cycle error pulse after a rejected transfer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end
`else
  // A zero ratio would stall the divider, so it is promoted to divide-by-1
  assign w_ratio_san = (cfg_ratio_i == {DIV_WIDTH{1'b0}}) ? DIV_WIDTH'(1) : cfg_ratio_i;
  assign w_reject    = 1'b0;
`endif

  // Sequencer state, counter, pending request and divider-facing registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_STABLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_pend_ratio <= {DIV_WIDTH{1'b0}};
      r_pend_en    <= 1'b0;
      r_div_en     <= 1'b0;
      r_div_ratio  <= DIV_WIDTH'(RESET_RATIO);
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pend_ratio <= w_pend_ratio_nxt;
      r_pend_en    <= w_pend_en_nxt;
      r_div_en     <= w_div_en_nxt;
      r_div_ratio  <= w_div_ratio_nxt;
    end
  end

  // Next-state logic: divider stays gated off across drain, load and settle
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_pend_ratio_nxt = r_pend_ratio;
    w_pend_en_nxt    = r_pend_en;
    w_div_en_nxt     = r_div_en;
    w_div_ratio_nxt  = r_div_ratio;
    case (r_state)
      ST_STABLE: begin
        if (w_xfer && !w_reject) begin
          if (w_ratio_san == r_div_ratio) begin
            w_div_en_nxt = cfg_en_i;
          end else begin
            w_pend_ratio_nxt = w_ratio_san;
            w_pend_en_nxt    = cfg_en_i;
            w_div_en_nxt     = 1'b0;
            w_state_nxt      = ST_DRAIN;
            w_cnt_nxt        = CNT_W'(DRAIN_CYCLES - 1);
          end
        end else begin
          w_div_en_nxt = r_div_en;
        end
      end
      ST_DRAIN: begin
        w_div_en_nxt = 1'b0;
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        w_div_en_nxt    = 1'b0;
        w_div_ratio_nxt = r_pend_ratio;
        w_state_nxt     = ST_SETTLE;
        w_cnt_nxt       = CNT_W'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt  = ST_STABLE;
          w_div_en_nxt = r_pend_en;
        end else begin
          w_cnt_nxt    = r_cnt - CNT_W'(1);
          w_div_en_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = ST_STABLE;
        w_div_en_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: per-cycle vector table plus hand-written reset-abort sequence.
module tb_clk_div_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       testmode_i;
  logic       cfg_valid_i;
  logic       cfg_ready_o;
  logic [7:0] cfg_ratio_i;
  logic       cfg_en_i;
  logic       div_en_o;
  logic [7:0] div_ratio_o;
  logic       busy_o;
  logic       err_w;

  int n_total = 0;
  int n_pass  = 0;

  clk_div_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .testmode_i  (testmode_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_ratio_i (cfg_ratio_i),
    .cfg_en_i    (cfg_en_i),
    .div_en_o    (div_en_o),
    .div_ratio_o (div_ratio_o),
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    .err_o       (err_w),
`endif
    .busy_o      (busy_o)
  );

`ifndef CLK_DIV_CTRL_RANGE_CHECK_EN
  assign err_w = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       tm;
    logic       valid;
    logic [7:0] ratio;
    logic       en;
    logic       e_rdy;
    logic       e_en;
    logic [7:0] e_ratio;
    logic       e_busy;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic tm, input logic valid, input logic [7:0] ratio,
                     input logic en, input logic e_rdy, input logic e_en, input logic [7:0] e_ratio,
                     input logic e_busy, input logic e_err);
    vec_t v;
    v.tm = tm; v.valid = valid; v.ratio = ratio; v.en = en;
    v.e_rdy = e_rdy; v.e_en = e_en; v.e_ratio = e_ratio; v.e_busy = e_busy; v.e_err = e_err;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic drive(input logic tm, input logic valid, input logic [7:0] ratio, input logic en);
    testmode_i = tm; cfg_valid_i = valid; cfg_ratio_i = ratio; cfg_en_i = en;
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    rst_i = 1'b1;

    // Columns: count, tm, valid, ratio, en | ready, div_en, div_ratio, busy, err
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'd8, 1'b1,  1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
    add(3, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd4, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd8, 1'b1, 1'b0);
    add(1, 1'b0, 1'b1, 8'd8, 1'b0,  1'b1, 1'b1, 8'd8, 1'b0, 1'b0);
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b0, 8'd8, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'd5, 1'b1,  1'b1, 1'b0, 8'd8, 1'b0, 1'b0);
    add(3, 1'b0, 1'b1, 8'd3, 1'b1,  1'b0, 1'b0, 8'd8, 1'b1, 1'b0);
    add(2, 1'b0, 1'b1, 8'd3, 1'b1,  1'b0, 1'b0, 8'd5, 1'b1, 1'b0);
    add(1, 1'b0, 1'b1, 8'd3, 1'b1,  1'b1, 1'b1, 8'd5, 1'b0, 1'b0);
    add(3, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd5, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd3, 1'b1, 1'b0);
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
    add(2, 1'b1, 1'b1, 8'd6, 1'b1,  1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 8'd6, 1'b1,  1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
    add(3, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd3, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd6, 1'b1, 1'b0);
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b1, 8'd6, 1'b0, 1'b0);
`ifdef CLK_DIV_CTRL_RANGE_CHECK_EN
    add(1, 1'b0, 1'b1, 8'd1, 1'b0,  1'b1, 1'b1, 8'd6, 1'b0, 1'b0);
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b1, 8'd6, 1'b0, 1'b1);
    add(1, 1'b0, 1'b1, 8'd0, 1'b0,  1'b1, 1'b1, 8'd6, 1'b0, 1'b0);
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b1, 8'd6, 1'b0, 1'b1);
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b1, 8'd6, 1'b0, 1'b0);
`else
    add(1, 1'b0, 1'b1, 8'd0, 1'b1,  1'b1, 1'b1, 8'd6, 1'b0, 1'b0);
    add(3, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd6, 1'b1, 1'b0);
    add(2, 1'b0, 1'b0, 8'd0, 1'b0,  1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
    add(1, 1'b0, 1'b1, 8'd1, 1'b0,  1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
    add(1, 1'b0, 1'b0, 8'd0, 1'b0,  1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
`endif

    // Reset state while reset is held
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_ready", {31'd0, cfg_ready_o}, 32'd1);
    check("rst_div_en", {31'd0, div_en_o}, 32'd0);
    check("rst_ratio", {24'd0, div_ratio_o}, 32'd4);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_err", {31'd0, err_w}, 32'd0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].tm, vecs[i].valid, vecs[i].ratio, vecs[i].en);
      #1;
      check($sformatf("v%0d_ready", i), {31'd0, cfg_ready_o}, {31'd0, vecs[i].e_rdy});
      check($sformatf("v%0d_div_en", i), {31'd0, div_en_o}, {31'd0, vecs[i].e_en});
      check($sformatf("v%0d_ratio", i), {24'd0, div_ratio_o}, {24'd0, vecs[i].e_ratio});
      check($sformatf("v%0d_busy", i), {31'd0, busy_o}, {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d_err", i), {31'd0, err_w}, {31'd0, vecs[i].e_err});
    end

    // Reset asserted while in LOAD: outputs revert without a clock edge, request is lost
    @(negedge clk_i);
    drive(1'b0, 1'b1, 8'd9, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      drive(1'b0, 1'b0, 8'd0, 1'b0);
      #1;
      check($sformatf("abort_busy_c%0d", c), {31'd0, busy_o}, 32'd1);
    end
    rst_i = 1'b1;
    #1;
    check("abort_ratio", {24'd0, div_ratio_o}, 32'd4);
    check("abort_div_en", {31'd0, div_en_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);
    #1;
    check("post_abort_ratio", {24'd0, div_ratio_o}, 32'd4);
    check("post_abort_div_en", {31'd0, div_en_o}, 32'd0);
    check("post_abort_busy", {31'd0, busy_o}, 32'd0);
    check("post_abort_ready", {31'd0, cfg_ready_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
